dna_population_seeder: RTL and testbench

//  Parametrised successor to the population DNA initializer. Seeds the gene RAM with random genes for every network in a population.

---
 rtl/dna_pkg.sv | 48 ++++
 rtl/dna_gene_sampler.sv | 45 ++++
 rtl/dna_population_seeder.sv | 175 +++++++++++++++++
 tb/tb_dna_population_seeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dna_pkg.sv
// Shared types, bus constants and gene-layout helpers
// for the population DNA seeder.
package dna_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } state_e;

  typedef enum logic {
    K_OUT,
    K_CONN
  } kind_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while (r < 31 && (1 << r) < v) r++;
    return r;
  endfunction

  function automatic int stride(input int outs,
                                input int neurons,
                                input int conns);
    return outs + neurons * conns;
  endfunction

  function automatic int total_words(input int outs,
                                     input int neurons,
                                     input int conns,
                                     input int nets);
    return stride(outs, neurons, conns) * nets;
  endfunction

  localparam int DEF_G     = stride(1, 2, 2);
  localparam int DEF_WORDS = total_words(1, 2, 2, 16);

endpackage

// File: rtl/dna_gene_sampler.sv
// Combinational rejection sampler: masks the random word to the
// next power of two and accepts only draws inside the gene range.
module dna_gene_sampler
  import dna_pkg::*;
#(
  parameter int INPUT_COUNT  = 1,
  parameter int NEURON_COUNT = 2,
  parameter int RAND_W       = 9
) (
  input  logic [RAND_W-1:0] rand_num_i,
  input  kind_e             kind_i,
  output logic [15:0]       gene_o,
  output logic              accept_o
);

  localparam int OW = clog2(NEURON_COUNT);
  localparam int CW = clog2(INPUT_COUNT + NEURON_COUNT);
  localparam logic [31:0] OMASK = (32'd1 << OW) - 32'd1;
  localparam logic [31:0] CMASK = (32'd1 << CW) - 32'd1;

  logic [31:0] rnd;
  logic [31:0] r;

  // mask, range-test and offset the draw for the selected gene kind
  always_comb begin
    rnd      = 32'(rand_num_i);
    r        = '0;
    gene_o   = '0;
    accept_o = 1'b0;
    unique case (kind_i)
      K_OUT: begin
        r        = rnd & OMASK;
        accept_o = r < 32'(NEURON_COUNT);
        gene_o   = 16'(r + 32'(INPUT_COUNT));
      end
      K_CONN: begin
        r        = rnd & CMASK;
        accept_o = r < 32'(INPUT_COUNT + NEURON_COUNT);
        gene_o   = 16'(r);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dna_population_seeder.sv
// Seeds gene RAM with uniform random genes for a whole population.
// Optional running gene checksum: define DNA_SEED_CHECKSUM_EN.
module dna_population_seeder
  import dna_pkg::*;
#(
  parameter int          INPUT_COUNT             = 1,
  parameter int          OUTPUT_COUNT            = 1,
  parameter int          NEURON_COUNT            = 2,
  parameter int          CONNECTIONS             = 2,
  parameter int          NETWORKS_PER_POPULATION = 16,
  parameter logic [22:0] BASE_ADDR               = 23'd0,
  parameter logic [1:0]  OWN_STATE               = 2'd0,
  parameter int          RAND_W                  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        net_state,
  input  logic              start,
  input  logic [RAND_W-1:0] rand_num,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum,
  inout  wire  [15:0]       ramBusDataIn,
  inout  wire  [22:0]       ramBusAddr,
  inout  wire               ramLatch,
  inout  wire               ramInstruction,
  input  logic              ramReady
);

  localparam int G     = stride(OUTPUT_COUNT, NEURON_COUNT, CONNECTIONS);
  localparam int TOTAL = G * NETWORKS_PER_POPULATION;
  localparam int GW    = clog2(G + 1);
  localparam int NW    = clog2(NETWORKS_PER_POPULATION + 1);

  if (int'(BASE_ADDR) + TOTAL > (1 << ADDR_W)) begin : g_chk_addr
    $error("dna_population_seeder: population exceeds 23-bit address space");
  end
  if (RAND_W < clog2(INPUT_COUNT + NEURON_COUNT)) begin : g_chk_rand
    $error("dna_population_seeder: RAND_W too narrow for gene range");
  end

  state_e          state_q;
  logic            busy_q;
  logic            done_q;
  logic            latch_q;
  logic [22:0]     addr_q;
  logic [22:0]     addr_d;
  logic [15:0]     data_q;
  logic [GW-1:0]   gene_q;
  logic [GW-1:0]   gene_d;
  logic [NW-1:0]   net_q;
  logic [NW-1:0]   net_d;

  logic            own;
  logic            go;
  logic            complete;
  logic            last_word;
  logic            accept;
  logic [15:0]     gene;
  kind_e           kind;

  assign own       = (net_state == OWN_STATE);
  assign go        = start && (state_q == S_IDLE || state_q == S_DONE);
  assign complete  = own && (state_q == S_WAIT_DONE) && ramReady;
  assign last_word = (gene_q == GW'(G - 1)) &&
                     (net_q == NW'(NETWORKS_PER_POPULATION - 1));
  assign kind      = (gene_q < GW'(OUTPUT_COUNT)) ? K_OUT : K_CONN;

  dna_gene_sampler #(
    .INPUT_COUNT (INPUT_COUNT),
    .NEURON_COUNT(NEURON_COUNT),
    .RAND_W      (RAND_W)
  ) u_sampler (
    .rand_num_i(rand_num),
    .kind_i    (kind),
    .gene_o    (gene),
    .accept_o  (accept)
  );

  // next word position: gene index wraps into the network counter
  always_comb begin
    addr_d = addr_q + 23'd1;
    gene_d = gene_q + GW'(1);
    net_d  = net_q;
    if (gene_q == GW'(G - 1)) begin
      gene_d = '0;
      net_d  = net_q + NW'(1);
    end
  end

  // seeding FSM; freezes without the bus, an un-acked write re-issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      latch_q <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      gene_q  <= '0;
      net_q   <= '0;
    end else begin
      latch_q <= 1'b0;
      if (go) begin
        state_q <= S_GEN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        addr_q  <= BASE_ADDR;
        gene_q  <= '0;
        net_q   <= '0;
      end else if (!own) begin
        if (state_q == S_WAIT_ACK) state_q <= S_ISSUE;
      end else begin
        unique case (state_q)
          S_GEN: begin
            if (accept) begin
              data_q  <= gene;
              state_q <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (ramReady) begin
              latch_q <= 1'b1;
              state_q <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (!ramReady) state_q <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (ramReady) begin
              if (last_word) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_GEN;
                addr_q  <= addr_d;
                gene_q  <= gene_d;
                net_q   <= net_d;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DNA_SEED_CHECKSUM_EN
  logic [15:0] sum_q;

  // running sum of every gene whose write has completed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sum_q <= '0;
    else if (go)       sum_q <= '0;
    else if (complete) sum_q <= sum_q + data_q;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  logic drive;
  assign drive = own && !rst;

  assign busy           = busy_q;
  assign done           = done_q;
  assign ramBusDataIn   = drive ? data_q  : {16{1'bz}};
  assign ramBusAddr     = drive ? addr_q  : {23{1'bz}};
  assign ramLatch       = drive ? latch_q : 1'bz;
  assign ramInstruction = drive ? WRITE   : 1'bz;

endmodule

// File: tb/tb_dna_population_seeder.sv
// Directed bench for dna_population_seeder with a simple RAM model.
// Released bus lines read as pull values (addr/data/latch 1, instr 0).
module tb_dna_population_seeder;

  localparam int G     = 5;
  localparam int TOTAL = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  net_state = 2'd0;
  logic        start = 1'b0;
  logic [8:0]  rand_num = 9'd0;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  tri1  [15:0] ramBusDataIn;
  tri1  [22:0] ramBusAddr;
  tri1         ramLatch;
  tri0         ramInstruction;
  logic        ramReady;

  logic        rdy_q = 1'b1;
  logic        stall = 1'b0;
  int          cnt = 0;
  logic        rfix_en = 1'b0;
  logic [8:0]  rfix = 9'd0;

  logic [22:0] wa[$];
  logic [15:0] wd[$];

  int total = 0;
  int bad = 0;

  assign ramReady = rdy_q && !stall;

  dna_population_seeder u_dut (
    .clk           (clk),
    .rst           (rst),
    .net_state     (net_state),
    .start         (start),
    .rand_num      (rand_num),
    .busy          (busy),
    .done          (done),
    .checksum      (checksum),
    .ramBusDataIn  (ramBusDataIn),
    .ramBusAddr    (ramBusAddr),
    .ramLatch      (ramLatch),
    .ramInstruction(ramInstruction),
    .ramReady      (ramReady)
  );

  always #5 clk = ~clk;

  // free-running or pinned random source
  always @(negedge clk) begin
    if (rfix_en) rand_num <= rfix;
    else         rand_num <= rand_num + 9'd1;
  end

  // RAM: ready drops one cycle after latch, back two cycles later
  always @(posedge clk) begin
    if (rst) begin
      cnt   <= 0;
      rdy_q <= 1'b1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) rdy_q <= 1'b1;
    end else if (net_state == 2'd0 && ramLatch === 1'b1) begin
      wa.push_back(ramBusAddr);
      wd.push_back(ramBusDataIn);
      rdy_q <= 1'b0;
      cnt   <= 2;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [22:0] a);
    int n;
    n = 0;
    while (ramBusAddr !== a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(ramBusAddr), 32'(a));
  endtask

  task automatic check_run(input string tag);
    int nbad;
    nbad = 0;
    chk({tag, "_cnt"}, wa.size(), TOTAL);
    foreach (wa[i]) if (wa[i] != 23'(i)) nbad++;
    chk({tag, "_addr"}, nbad, 0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_data(input string tag,
                            input logic [15:0] eo,
                            input logic [15:0] ec);
    int nbad;
    nbad = 0;
    foreach (wd[i]) begin
      if (i == 0 && tag == "rej") begin
        if (wd[i] != 16'd2) nbad++;
      end else if (i % G == 0) begin
        if (wd[i] != eo) nbad++;
      end else if (wd[i] != ec) nbad++;
    end
    chk({tag, "_data"}, nbad, 0);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    int cyc;
    int viol;
    logic [15:0] d0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(checksum), 32'd0);
    chk("rst_addr_z", 32'(ramBusAddr), 32'h7fffff);
    chk("rst_instr_z", 32'(ramInstruction), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_addr", 32'(ramBusAddr), 32'd0);
    chk("idle_latch", 32'(ramLatch), 32'd0);
    chk("idle_instr", 32'(ramInstruction), 32'd1);

    // full run with sweeping random values: genes stay in range
    clear_log();
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", cyc);
    check_run("t1");
    viol = 0;
    foreach (wd[i]) begin
      if (i % G == 0) begin
        if (wd[i] < 16'd1 || wd[i] > 16'd2) viol++;
      end else if (wd[i] > 16'd2) viol++;
    end
    chk("t1_range", viol, 0);

    // RAM stall before word 5: nothing issues, bus holds steady
    rfix_en = 1'b1;
    rfix    = 9'd1;
    @(negedge clk);
    clear_log();
    pulse_start();
    wait_addr("t3_reach", 23'd5);
    stall = 1'b1;
    @(negedge clk);
    d0 = ramBusDataIn;
    chk("t3_data", 32'(d0), 32'd2);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (ramLatch !== 1'b0) viol++;
      if (ramBusAddr !== 23'd5) viol++;
      if (ramBusDataIn !== d0) viol++;
    end
    chk("t3_stable", viol, 0);
    chk("t3_nowrite", wa.size(), 5);
    stall = 1'b0;
    wait_done("t3_done", cyc);
    check_run("t3");

    // bus lost while word 7 awaits ack
    rfix_en = 1'b0;
    clear_log();
    pulse_start();
    cyc = 0;
    while (!(ramLatch === 1'b1 && ramBusAddr === 23'd7) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_reach", 32'(ramBusAddr), 32'd7);
    net_state = 2'd1;
    @(negedge clk);
    chk("t4_latch_z", 32'(ramLatch), 32'd1);
    chk("t4_addr_z", 32'(ramBusAddr), 32'h7fffff);
    chk("t4_data_z", 32'(ramBusDataIn), 32'hffff);
    chk("t4_instr_z", 32'(ramInstruction), 32'd0);
    repeat (19) @(negedge clk);
    chk("t4_hold", wa.size(), 7);
    net_state = 2'd0;
    wait_done("t4_done", cyc);
    check_run("t4");

    // reset in the middle of a run, then a fresh run
    clear_log();
    pulse_start();
    wait_addr("t5_reach", 23'd20);
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_addr_z", 32'(ramBusAddr), 32'h7fffff);
    chk("t5_instr_z", 32'(ramInstruction), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_addr_base", 32'(ramBusAddr), 32'd0);
    clear_log();
    pulse_start();
    wait_done("t5_done2", cyc);
    check_run("t5");

    // value 3 rejected for connection genes: run stalls in GEN
    rfix_en = 1'b1;
    rfix    = 9'd3;
    @(negedge clk);
    clear_log();
    pulse_start();
    repeat (30) @(negedge clk);
    chk("t2_one", wa.size(), 1);
    chk("t2_first", (wd.size() > 0) ? 32'(wd[0]) : 32'hdead, 32'd2);
    chk("t2_addr", 32'(ramBusAddr), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    rfix = 9'd2;
    wait_done("t2_done", cyc);
    check_run("t2");
    check_data("rej", 16'd1, 16'd2);
`ifdef DNA_SEED_CHECKSUM_EN
    chk("t2_sum", 32'(checksum), 32'd145);
`else
    chk("t2_sum", 32'(checksum), 32'd0);
`endif

    // pinned draw of 1: fixed genes, checksum and exact cycle count
    rfix = 9'd1;
    @(negedge clk);
    clear_log();
    pulse_start();
    chk("t6_done_clr", 32'(done), 32'd0);
    chk("t6_sum_clr", 32'(checksum), 32'd0);
    wait_done("t6_done", cyc);
    chk("t6_cycles", cyc, 480);
    check_run("t6");
    check_data("fix", 16'd2, 16'd1);
`ifdef DNA_SEED_CHECKSUM_EN
    chk("t6_sum", 32'(checksum), 32'd96);
`else
    chk("t6_sum", 32'(checksum), 32'd0);
`endif
    pulse_start();
    chk("t6_restart_sum", 32'(checksum), 32'd0);
    chk("t6_restart_busy", 32'(busy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
